// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// FSM state encoding and a constant-evaluable clog2 helper.
package mult_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY,
        S_DONE = ST_DONE
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Radix-2 shift-add datapath: mcand/mplier/acc registers plus the product
// register, driven by load/step/finish strobes from the control FSM.
// Ports: clk, rst_n, load, step, finish, a, b, [signed_op], product.
// Optional: SIGNED_MULT_EN adds signed_op and sign-magnitude correction.
module shift_add_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               finish,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MULT_EN
    input  logic               signed_op,
`endif
    output logic [2*WIDTH-1:0] product
);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   a_mag, b_mag;
`ifdef SIGNED_MULT_EN
    logic               neg_q, neg_d;
`endif

    always_comb begin
        a_mag = a;
        b_mag = b;
`ifdef SIGNED_MULT_EN
        // -2^(W-1) negates to itself, which is its correct unsigned magnitude
        if (signed_op && a[WIDTH-1]) a_mag = -a;
        if (signed_op && b[WIDTH-1]) b_mag = -b;
`endif
        // value acc takes on this step; also the final result on finish
        acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        product_d = product_q;
`ifdef SIGNED_MULT_EN
        neg_d     = neg_q;
`endif
        if (load) begin
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            acc_d    = '0;
`ifdef SIGNED_MULT_EN
            neg_d    = signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
        end else if (step) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
        if (finish) begin
`ifdef SIGNED_MULT_EN
            product_d = neg_q ? -acc_sum : acc_sum;
`else
            product_d = acc_sum;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
`ifdef SIGNED_MULT_EN
            neg_q     <= 1'b0;
`endif
        end else begin
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            product_q <= product_d;
`ifdef SIGNED_MULT_EN
            neg_q     <= neg_d;
`endif
        end
    end

    assign product = product_q;

endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Sequential WIDTH x WIDTH -> 2*WIDTH shift-add multiplier with valid/ready
// handshakes on operand and product sides; fixed WIDTH-cycle compute latency.
// Ports: clk, rst_n, in_valid, in_ready, a, b, [signed_op], out_valid,
//        out_ready, product, busy. Optional: SIGNED_MULT_EN (signed_op port).
module seq_shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MULT_EN
    input  logic               signed_op,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int CNT_W = clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load, step, finish;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                step  = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    finish  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // handshake outputs depend on registered state only
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);

    shift_add_datapath #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .step      (step),
        .finish    (finish),
        .a         (a),
        .b         (b),
`ifdef SIGNED_MULT_EN
        .signed_op (signed_op),
`endif
        .product   (product)
    );

endmodule
